// File: rtl/pc_unit.sv
// pc_unit: holds the fetch program counter and picks the next PC from trap, redirect,
//   RAS pop, call target or sequential increment. A small circular return-address stack
//   predicts call/return targets.
// Ports: clk, rst (async, active-low);
//   fetch_valid/fetch_ready/pc carry the fetch request;
//   trap, redirect/redirect_pc, call/call_target and ret steer the next PC;
//   ras_count/ras_empty report RAS occupancy.
// Latency: all outputs are registered, so the selected next PC appears one cycle after
//   the deciding edge. Backpressure: with fetch_ready low, pc and the RAS hold; trap and
//   redirect still act.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h100),
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fetch_ready,
  output logic                           fetch_valid,
  output logic [WIDTH-1:0]               pc,
  input  logic                           trap,
  input  logic                           redirect,
  input  logic [WIDTH-1:0]               redirect_pc,
  input  logic                           call,
  input  logic [WIDTH-1:0]               call_target,
  input  logic                           ret,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = $clog2(RAS_DEPTH);

  logic             r_valid;
  logic [WIDTH-1:0] r_pc;
  logic [PW-1:0]    r_ptr;    // next free slot; the top of the stack is at r_ptr-1
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];

  logic             w_acc;
  logic             w_empty;
  logic             w_ctl_ok;
  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_ptr_m1;
  logic [PW-1:0]    w_wr_idx;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_next_pc;

  assign w_acc    = r_valid & fetch_ready;
  assign w_empty  = (r_count == '0);
  // Trap or redirect overrides the predecode hints for this cycle.
  assign w_ctl_ok = ~trap & ~redirect;
  assign w_push   = w_ctl_ok & w_acc & call;
  assign w_pop    = w_ctl_ok & w_acc & ret & ~w_empty;
  assign w_ptr_m1 = r_ptr - PW'(1);
  assign w_inc    = r_pc + WIDTH'(INC);
  assign w_top    = r_ras[w_ptr_m1];
  // On call+ret with a non-empty stack, the pushed value reuses the slot just popped.
  assign w_wr_idx = w_pop ? w_ptr_m1 : r_ptr;

  always_comb begin
    w_next_pc = r_pc;
    if (trap)                            w_next_pc = TRAP_VECTOR;
    else if (redirect)                   w_next_pc = redirect_pc;
    else if (w_acc && ret && !w_empty)   w_next_pc = w_top;
    else if (w_acc && ret)               w_next_pc = w_inc;
    else if (w_acc && call)              w_next_pc = call_target;
    else if (w_acc)                      w_next_pc = w_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_pc    <= RESET_VECTOR;
      r_ptr   <= '0;
      r_count <= '0;
    end else begin
      r_valid <= 1'b1;
      r_pc    <= w_next_pc;
      if (trap) begin
        r_ptr   <= '0;
        r_count <= '0;
      end else if (w_push && !w_pop) begin
        // When the stack is full, the write lands on the oldest entry and the count saturates.
        r_ptr <= r_ptr + PW'(1);
        if (r_count != CW'(RAS_DEPTH)) r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_ptr   <= w_ptr_m1;
        r_count <= r_count - CW'(1);
      end
    end
  end

  // The entries hold no reset state; they are only read when ras_count shows them valid.
  always_ff @(posedge clk) begin
    if (w_push) r_ras[w_wr_idx] <= w_inc;
  end

  assign fetch_valid = r_valid;
  assign pc          = r_pc;
  assign ras_count   = r_count;
  assign ras_empty   = w_empty;

endmodule
